// File: rtl/flash_led_pkg.sv
// Shared types and helpers for the flash_led input and display blocks:
// the debounce FSM state encoding and the ms-to-cycles constant function.
package flash_led_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    PRESSED    = 2'd2,
    RELEASE_DB = 2'd3
  } btn_state_e;

  // Clock cycles covering ms milliseconds, never less than one cycle.
  function automatic longint unsigned cycles_from_ms(input longint unsigned cps,
                                                     input longint unsigned ms);
    longint unsigned c;
    c = (cps * ms) / 64'd1000;
    return (c < 64'd1) ? 64'd1 : c;
  endfunction

endpackage

// File: rtl/dir_btn_debounce_sync_2ff.sv
// Parameterised-width two-flop synchroniser (d -> s1 -> q), synchronous reset to 0.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1_reg;
  logic [W-1:0] s2_reg;

  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_bit
      always_ff @(posedge clk) begin
        if (rst) begin
          s1_reg[gi] <= 1'b0;
          s2_reg[gi] <= 1'b0;
        end else begin
          s1_reg[gi] <= d[gi];
          s2_reg[gi] <= s1_reg[gi];
        end
      end
    end
  endgenerate

  assign q = s2_reg;

endmodule

// File: rtl/dir_btn_debounce.sv
// Direction button conditioner: synchronise, debounce, toggle dir per accepted press,
// flag long holds. Optional DIR_BTN_LONG_PRESS_RESET_EN: a long hold forces dir back to 0.
module dir_btn_debounce
  import flash_led_pkg::*;
#(
  parameter int unsigned CYCLES_PER_SECOND = 100_000_000,
  parameter int unsigned DEBOUNCE_MS       = 20,
  parameter int unsigned LONG_PRESS_MS     = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic dir,
  output logic dir_toggle,
  output logic long_press
);

  localparam longint unsigned DB_CYC = cycles_from_ms(64'(CYCLES_PER_SECOND), 64'(DEBOUNCE_MS));
  localparam longint unsigned LP_CYC = cycles_from_ms(64'(CYCLES_PER_SECOND), 64'(LONG_PRESS_MS));
  localparam int DB_W = $clog2(DB_CYC + 64'd1);
  localparam int LP_W = $clog2(LP_CYC + 64'd1);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DB_CYC);
  localparam logic [LP_W-1:0] LP_MAX = LP_W'(LP_CYC);

  logic s2;

  sync_2ff #(.W(1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (s2)
  );

  btn_state_e      state_reg, state_next;
  logic [DB_W-1:0] db_cnt_reg, db_cnt_next;
  logic [LP_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic            dir_reg, dir_next;
  logic            btn_level_reg, btn_level_next;
  logic            dir_toggle_reg, dir_toggle_next;
  logic            long_press_reg, long_press_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      db_cnt_reg     <= '0;
      hold_cnt_reg   <= '0;
      dir_reg        <= 1'b0;
      btn_level_reg  <= 1'b0;
      dir_toggle_reg <= 1'b0;
      long_press_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      db_cnt_reg     <= db_cnt_next;
      hold_cnt_reg   <= hold_cnt_next;
      dir_reg        <= dir_next;
      btn_level_reg  <= btn_level_next;
      dir_toggle_reg <= dir_toggle_next;
      long_press_reg <= long_press_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    db_cnt_next     = db_cnt_reg;
    hold_cnt_next   = hold_cnt_reg;
    dir_next        = dir_reg;
    btn_level_next  = btn_level_reg;
    dir_toggle_next = 1'b0;
    long_press_next = 1'b0;

    // Hold time runs while the press is accepted; saturation makes the pulse one-shot.
    if ((state_reg == PRESSED || state_reg == RELEASE_DB) && hold_cnt_reg != LP_MAX) begin
      hold_cnt_next = hold_cnt_reg + LP_W'(1);
      if (hold_cnt_reg == LP_MAX - LP_W'(1)) long_press_next = 1'b1;
    end

    unique case (state_reg)
      IDLE: begin
        btn_level_next = 1'b0;
        hold_cnt_next  = '0;
        db_cnt_next    = '0;
        if (s2) begin
          state_next  = PRESS_DB;
          db_cnt_next = DB_W'(1);
        end
      end
      PRESS_DB: begin
        if (!s2) begin
          state_next  = IDLE;
          db_cnt_next = '0;
        end else if (db_cnt_reg == DB_MAX) begin
          state_next      = PRESSED;
          db_cnt_next     = '0;
          hold_cnt_next   = '0;
          btn_level_next  = 1'b1;
          dir_next        = ~dir_reg;
          dir_toggle_next = 1'b1;
        end else begin
          db_cnt_next = db_cnt_reg + DB_W'(1);
        end
      end
      PRESSED: begin
        if (!s2) begin
          state_next  = RELEASE_DB;
          db_cnt_next = DB_W'(1);
        end
      end
      RELEASE_DB: begin
        // A bounce back to pressed resumes the same press: no re-toggle, hold kept.
        if (s2) begin
          state_next  = PRESSED;
          db_cnt_next = '0;
        end else if (db_cnt_reg == DB_MAX) begin
          state_next     = IDLE;
          db_cnt_next    = '0;
          hold_cnt_next  = '0;
          btn_level_next = 1'b0;
        end else begin
          db_cnt_next = db_cnt_reg + DB_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase

`ifdef DIR_BTN_LONG_PRESS_RESET_EN
    // Long hold returns dir to 0; only report a toggle if it actually moved.
    if (long_press_next) begin
      dir_next        = 1'b0;
      dir_toggle_next = dir_reg;
    end
`endif
  end

  assign btn_level  = btn_level_reg;
  assign dir        = dir_reg;
  assign dir_toggle = dir_toggle_reg;
  assign long_press = long_press_reg;

endmodule

// File: tb/tb_dir_btn_debounce.sv
// Bench for dir_btn_debounce with DB_CYC=5, LP_CYC=20: hand-written latency sequences
// followed by a table of directed segments checked at segment end.
module tb_dir_btn_debounce;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_in = 1'b0;
  logic btn_level, dir, dir_toggle, long_press;

  int checks = 0;
  int errors = 0;
  int tog_cnt = 0;
  int lp_cnt = 0;

  dir_btn_debounce #(
    .CYCLES_PER_SECOND (100),
    .DEBOUNCE_MS       (50),
    .LONG_PRESS_MS     (200)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_in     (btn_in),
    .btn_level  (btn_level),
    .dir        (dir),
    .dir_toggle (dir_toggle),
    .long_press (long_press)
  );

  always #5 clk = ~clk;

`ifdef DIR_BTN_LONG_PRESS_RESET_EN
  localparam bit LP_RST = 1'b1;
`else
  localparam bit LP_RST = 1'b0;
`endif

  typedef struct {
    string name;
    logic  rst;
    logic  btn;
    int    len;
    logic  exp_dir;
    logic  exp_lvl;
    int    exp_tog;
    int    exp_lp;
  } vec_t;

  vec_t vecs[19];

  function automatic vec_t mk(string n, logic r, logic b, int l, logic d, logic lv, int t, int p);
    vec_t v;
    v.name = n; v.rst = r; v.btn = b; v.len = l;
    v.exp_dir = d; v.exp_lvl = lv; v.exp_tog = t; v.exp_lp = p;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: outputs sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    tog_cnt += int'(dir_toggle);
    lp_cnt  += int'(long_press);
  endtask

  initial begin
    vecs[0]  = mk("reset",         1'b1, 1'b0, 2,  1'b0, 1'b0, 0, 0);
    vecs[1]  = mk("clean_press",   1'b0, 1'b1, 10, 1'b1, 1'b1, 1, 0);
    vecs[2]  = mk("clean_release", 1'b0, 1'b0, 10, 1'b1, 1'b0, 0, 0);
    vecs[3]  = mk("glitch_hi4",    1'b0, 1'b1, 4,  1'b1, 1'b0, 0, 0);
    vecs[4]  = mk("glitch_lo",     1'b0, 1'b0, 10, 1'b1, 1'b0, 0, 0);
    vecs[5]  = mk("bounce_hi_a",   1'b0, 1'b1, 2,  1'b1, 1'b0, 0, 0);
    vecs[6]  = mk("bounce_lo_a",   1'b0, 1'b0, 2,  1'b1, 1'b0, 0, 0);
    vecs[7]  = mk("bounce_hi_b",   1'b0, 1'b1, 2,  1'b1, 1'b0, 0, 0);
    vecs[8]  = mk("bounce_lo_b",   1'b0, 1'b0, 2,  1'b1, 1'b0, 0, 0);
    vecs[9]  = mk("bounce_hold",   1'b0, 1'b1, 10, 1'b0, 1'b1, 1, 0);
    vecs[10] = mk("rel_bounce_lo", 1'b0, 1'b0, 3,  1'b0, 1'b1, 0, 0);
    vecs[11] = mk("rel_bounce_hi", 1'b0, 1'b1, 3,  1'b0, 1'b1, 0, 0);
    vecs[12] = mk("rel_final",     1'b0, 1'b0, 12, 1'b0, 1'b0, 0, 0);
    vecs[13] = mk("long_hold",     1'b0, 1'b1, 40, LP_RST ? 1'b0 : 1'b1, 1'b1, LP_RST ? 2 : 1, 1);
    vecs[14] = mk("long_release",  1'b0, 1'b0, 12, LP_RST ? 1'b0 : 1'b1, 1'b0, 0, 0);
    vecs[15] = mk("reset2",        1'b1, 1'b0, 2,  1'b0, 1'b0, 0, 0);
    vecs[16] = mk("press_a",       1'b0, 1'b1, 10, 1'b1, 1'b1, 1, 0);
    vecs[17] = mk("idle_gap",      1'b0, 1'b0, 20, 1'b1, 1'b0, 0, 0);
    vecs[18] = mk("press_b",       1'b0, 1'b1, 10, 1'b0, 1'b1, 1, 0);

    // Settle in reset.
    rst = 1'b1; btn_in = 1'b0;
    repeat (3) tick();

    // Button held through reset: outputs stay 0, then it counts as a fresh press.
    btn_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_dir", dir, 0);
      chk("rst_level", btn_level, 0);
      chk("rst_toggle", dir_toggle, 0);
      chk("rst_long", long_press, 0);
    end
    rst = 1'b0;
    tog_cnt = 0; lp_cnt = 0;
    for (int t = 1; t <= 9; t++) begin
      tick();
      if (t == 7) chk("rst_press_tog_early", dir_toggle, 0);
      if (t == 8) begin
        chk("rst_press_tog", dir_toggle, 1);
        chk("rst_press_dir", dir, 1);
        chk("rst_press_level", btn_level, 1);
      end
      if (t == 9) chk("rst_press_tog_once", dir_toggle, 0);
    end
    btn_in = 1'b0;
    repeat (12) tick();
    chk("rst_press_rel_level", btn_level, 0);
    chk("rst_press_rel_dir", dir, 1);
    chk("rst_press_no_long", lp_cnt, 0);

    // Exact long-press timing from a clean dir=0 start.
    rst = 1'b1; tick(); rst = 1'b0; tick();
    btn_in = 1'b1;
    tog_cnt = 0; lp_cnt = 0;
    for (int t = 1; t <= 40; t++) begin
      tick();
      if (t == 8) chk("lh_toggle", dir_toggle, 1);
      if (t == 27) chk("lh_long_early", long_press, 0);
      if (t == 28) begin
        chk("lh_long", long_press, 1);
        chk("lh_long_dir", dir, LP_RST ? 0 : 1);
        chk("lh_long_tog", dir_toggle, LP_RST ? 1 : 0);
      end
      if (t == 29) chk("lh_long_once", long_press, 0);
    end
    chk("lh_long_count", lp_cnt, 1);
    btn_in = 1'b0;
    repeat (12) tick();

    // Table of directed segments.
    for (int i = 0; i < 19; i++) begin
      rst = vecs[i].rst;
      btn_in = vecs[i].btn;
      tog_cnt = 0; lp_cnt = 0;
      repeat (vecs[i].len) tick();
      chk({vecs[i].name, "_dir"}, dir, vecs[i].exp_dir);
      chk({vecs[i].name, "_level"}, btn_level, vecs[i].exp_lvl);
      chk({vecs[i].name, "_toggles"}, tog_cnt, vecs[i].exp_tog);
      chk({vecs[i].name, "_longs"}, lp_cnt, vecs[i].exp_lp);
      $display("vec %0d %s: dir=%0d level=%0d toggles=%0d longs=%0d", i, vecs[i].name,
               dir, btn_level, tog_cnt, lp_cnt);
    end
    btn_in = 1'b0;
    tog_cnt = 0; lp_cnt = 0;
    repeat (12) tick();
    chk("final_rel_dir", dir, 0);
    chk("final_rel_level", btn_level, 0);
    chk("final_rel_toggles", tog_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
